// File: rtl/nibble_packer.sv
// Packs a stream of 4-bit samples into 16-bit words (first nibble in the LSBs)
// and queues the completed words in a small FIFO with a sticky overflow flag.
module nibble_packer #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [3:0]               in_data,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [15:0]              out_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [1:0]       idx_q, idx_d;
  logic [11:0]      partial_q, partial_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             overflow_q, overflow_d;
  logic [15:0]      mem_q [DEPTH];

  logic        accept;
  logic        push_req;
  logic        push;
  logic        pop;
  logic        full;
  logic [15:0] word;

  always_comb begin
    accept   = in_valid && !flush;
    push_req = accept && (idx_q == 2'd3);
    word     = {in_data, partial_q};
    full     = (level_q == LVL_W'(DEPTH));
    pop      = (level_q != '0) && out_ready;
    // A full FIFO still takes the new word when the head leaves in the same cycle.
    push     = push_req && (!full || pop);
  end

  always_comb begin
    idx_d     = idx_q;
    partial_d = partial_q;
    if (flush) begin
      idx_d     = 2'd0;
      partial_d = 12'd0;
    end else if (in_valid) begin
      idx_d = idx_q + 2'd1;
      case (idx_q)
        2'd0:    partial_d[3:0]  = in_data;
        2'd1:    partial_d[7:4]  = in_data;
        2'd2:    partial_d[11:8] = in_data;
        default: partial_d       = 12'd0;
      endcase
    end
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q + LVL_W'(push) - LVL_W'(pop);
    overflow_d = overflow_q || (push_req && full && !pop);
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q      <= 2'd0;
      partial_q  <= 12'd0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      idx_q      <= idx_d;
      partial_q  <= partial_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset; only the occupancy state decides what is visible.
  always_ff @(posedge clk) begin
    if (!rst && push) mem_q[wr_ptr_q] <= word;
  end

  assign out_valid = (level_q != '0);
  assign out_data  = mem_q[rd_ptr_q];
  assign level     = level_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_nibble_packer.sv
// Directed bench for nibble_packer: a queue scoreboard tracks expected words,
// checked every cycle against out_valid/out_data/level/overflow.
module tb_nibble_packer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [3:0]  in_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [2:0]  level;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_q [$];
  logic [1:0]  idx_m;
  logic [11:0] partial_m;
  logic        ovf_m;

  nibble_packer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .level(level), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    idx_m     = 2'd0;
    partial_m = 12'd0;
    ovf_m     = 1'b0;
  endtask

  // One clock cycle: check pre-edge outputs, drive inputs, advance the model.
  task automatic step(input logic v, input logic [3:0] d, input logic f, input logic rdy);
    logic full_m, pop_m;
    @(negedge clk);
    chk("out_valid", 32'(out_valid), 32'(exp_q.size() > 0));
    chk("level", 32'(level), 32'(exp_q.size()));
    chk("overflow", 32'(overflow), 32'(ovf_m));
    in_valid  = v;
    in_data   = d;
    flush     = f;
    out_ready = rdy;
    full_m = (exp_q.size() == DEPTH);
    pop_m  = (exp_q.size() > 0) && rdy;
    if (pop_m) begin
      chk("pop_data", 32'(out_data), 32'(exp_q[0]));
      $display("pop  word=%04h level=%0d", out_data, level);
    end
    if (f) begin
      idx_m     = 2'd0;
      partial_m = 12'd0;
    end else if (v) begin
      if (idx_m == 2'd3) begin
        $display("push word=%04h full=%0d pop=%0d", {d, partial_m}, full_m, pop_m);
        if (!full_m || pop_m) exp_q.push_back({d, partial_m});
        else ovf_m = 1'b1;
        partial_m = 12'd0;
      end else begin
        partial_m[4*idx_m +: 4] = d;
      end
      idx_m = idx_m + 2'd1;
    end
    if (pop_m) void'(exp_q.pop_front());
    @(posedge clk);
  endtask

  // Reset with every other input active so that rst priority is exercised.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b1; in_data = 4'hF; flush = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    model_clear();
    $display("reset applied");
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = 4'h0; flush = 1'b0; out_ready = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_level", 32'(level), 32'd0);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_overflow", 32'(overflow), 32'd0);

    // Streaming with a ready consumer: 3210, 7654, BA98, FEDC.
    do_reset();
    for (int i = 0; i < 16; i++) step(1'b1, 4'(i), 1'b0, 1'b1);
    repeat (3) step(1'b0, 4'h0, 1'b0, 1'b1);

    // Stalled consumer: fifth word dropped, overflow sticks.
    do_reset();
    for (int i = 0; i < 20; i++) step(1'b1, 4'(i), 1'b0, 1'b0);
    step(1'b0, 4'h0, 1'b0, 1'b0);
    chk("ovf_level", 32'(level), 32'd4);
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_head", 32'(out_data), 32'h3210);
    repeat (6) step(1'b0, 4'h0, 1'b0, 1'b1);
    chk("ovf_sticky", 32'(overflow), 32'd1);

    // Full FIFO with a pop in the same cycle as the completing nibble.
    do_reset();
    for (int i = 0; i < 16; i++) step(1'b1, 4'(i), 1'b0, 1'b0);
    step(1'b1, 4'h0, 1'b0, 1'b0);
    step(1'b1, 4'h1, 1'b0, 1'b0);
    step(1'b1, 4'h2, 1'b0, 1'b0);
    step(1'b1, 4'h3, 1'b0, 1'b1);
    step(1'b0, 4'h0, 1'b0, 1'b0);
    chk("full_pop_level", 32'(level), 32'd4);
    chk("full_pop_ovf", 32'(overflow), 32'd0);
    chk("full_pop_head", 32'(out_data), 32'h7654);
    repeat (5) step(1'b0, 4'h0, 1'b0, 1'b1);

    // Flush discards the partial word and ignores in_valid that cycle.
    do_reset();
    step(1'b1, 4'h5, 1'b0, 1'b1);
    step(1'b1, 4'h6, 1'b0, 1'b1);
    step(1'b1, 4'h9, 1'b1, 1'b1);
    for (int i = 1; i <= 4; i++) step(1'b1, 4'(i), 1'b0, 1'b0);
    step(1'b0, 4'h0, 1'b0, 1'b0);
    chk("flush_word", 32'(out_data), 32'h4321);
    chk("flush_level", 32'(level), 32'd1);
    step(1'b0, 4'h0, 1'b0, 1'b1);
    step(1'b0, 4'h0, 1'b0, 1'b1);

    // Reset mid-word.
    do_reset();
    step(1'b1, 4'hA, 1'b0, 1'b0);
    step(1'b1, 4'hB, 1'b0, 1'b0);
    step(1'b1, 4'hC, 1'b0, 1'b0);
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 4'(i), 1'b0, 1'b0);
    step(1'b0, 4'h0, 1'b0, 1'b0);
    chk("rst_mid_word", 32'(out_data), 32'h3210);
    chk("rst_mid_level", 32'(level), 32'd1);
    chk("rst_mid_ovf", 32'(overflow), 32'd0);
    step(1'b0, 4'h0, 1'b0, 1'b1);
    step(1'b0, 4'h0, 1'b0, 1'b1);

    // Gapped input: invalid cycles do not advance the index.
    do_reset();
    step(1'b1, 4'h1, 1'b0, 1'b1);
    step(1'b0, 4'h7, 1'b0, 1'b1);
    step(1'b1, 4'h2, 1'b0, 1'b1);
    step(1'b0, 4'h8, 1'b0, 1'b1);
    step(1'b1, 4'h3, 1'b0, 1'b1);
    step(1'b0, 4'h9, 1'b0, 1'b1);
    step(1'b1, 4'h4, 1'b0, 1'b0);
    step(1'b0, 4'h0, 1'b0, 1'b0);
    chk("gap_word", 32'(out_data), 32'h4321);
    step(1'b0, 4'h0, 1'b0, 1'b1);
    step(1'b0, 4'h0, 1'b0, 1'b1);
    chk("gap_drained", 32'(out_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/nibble_packer.md
NIBBLE_PACKER -- requirements
Module: nibble_packer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning FIFO depth in 16-bit words; legal values are powers of two, 2 to 16.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  in_data is valid this cycle; there is no input back-pressure.
REQ-005 SHALL have port in_data  input  4  nibble sample, typically a free-running 4-bit counter value.
REQ-006 SHALL have port flush  input  1  discards the partially assembled word.
REQ-007 SHALL have port out_valid  output  1  FIFO head word available.
REQ-008 SHALL have port out_ready  input  1  consumer accepts the head word when out_valid is also high.
REQ-009 SHALL have port out_data  output  16  FIFO head word; defined only while out_valid is high.
REQ-010 SHALL have port level  output  $clog2(DEPTH)+1  number of words held in the FIFO.
REQ-011 SHALL have port overflow  output  1  sticky flag: a completed word was dropped.

Function
REQ-012 SHALL keep a 2-bit nibble index and a 12-bit partial register; each cycle with in_valid high and flush low is an accepted nibble.
REQ-013 SHALL place nibble k (k = 0..3, in arrival order) at bits [4k+3:4k]; the first nibble accepted lands in bits [3:0].
REQ-014 SHALL complete a word on the 4th accepted nibble: {in_data, partial[11:0]} is pushed into the FIFO in that same cycle, and the index wraps 3 -> 0.
REQ-015 SHALL have a latency from 4th-nibble cycle N to out_valid of exactly 1 cycle when the FIFO was empty, and SHALL NOT provide a combinational bypass.
REQ-016 SHALL pop the FIFO on any cycle with out_valid high and out_ready high; out_data then advances to the next word on the following cycle.
REQ-017 SHALL hold out_data and out_valid stable while out_valid is high and out_ready is low.
REQ-018 SHALL handle a push when level==DEPTH as follows: without a same-cycle pop, the word is dropped, FIFO contents are unchanged, and overflow is set; with a same-cycle pop, the push is accepted and level stays at DEPTH.
REQ-019 SHALL handle a simultaneous push and pop at 0<level<DEPTH by leaving level unchanged.
REQ-020 SHALL handle a push at level==0 (no pop is possible) by moving level to 1.
REQ-021 SHALL clear the nibble index and partial register on a cycle with flush high, and SHALL ignore in_valid in that cycle; FIFO, level and overflow are unaffected.
REQ-022 SHALL implement read and write pointers as $clog2(DEPTH) bits that wrap modulo DEPTH, with level = occupancy counter, never exceeding DEPTH and never underflowing.
REQ-023 SHALL ignore out_ready while out_valid is low.
REQ-024 SHALL hold overflow at 1 once set, until rst.

Reset
REQ-025 SHALL, on a clk edge with rst high, clear nibble index, partial register, pointers, level, out_valid and overflow to 0; out_data is don't-care.
REQ-026 SHALL give rst priority over in_valid, flush and out_ready in the same cycle.
REQ-027 SHALL, when rst is asserted mid-word, discard the partial word; the first nibble accepted after rst deasserts is nibble 0.
REQ-028 SHALL have outputs valid from the first cycle after rst deasserts: out_valid=0, level=0, overflow=0.

Verification
REQ-029 SHALL cover: rst 1 cycle, then in_valid=1 with in_data 0,1,...,F, out_ready=1 -> out_data 0x3210, 0x7654, 0xBA98, 0xFEDC, each out_valid one cycle after its 4th nibble; overflow=0.
REQ-030 SHALL cover: out_ready=0, 20 nibbles 0..F,0..3 with DEPTH=4 -> level=4, 5th word (0x3210) dropped, overflow=1; then out_ready=1 drains 0x3210, 0x7654, 0xBA98, 0xFEDC.
REQ-031 SHALL cover: FIFO full (level=4), out_ready=1 in the same cycle as the 4th nibble of a word -> no drop, level stays 4, overflow stays 0.
REQ-032 SHALL cover: nibbles 5,6 then flush=1, then nibbles 1,2,3,4 -> single word 0x4321.
REQ-033 SHALL cover: nibbles A,B,C, rst 1 cycle, then nibbles 0,1,2,3 -> single word 0x3210, level=1, overflow=0.
REQ-034 SHALL cover: in_valid toggling 1,0,1,0 with nibbles 1,2,3,4 on the valid cycles -> word 0x4321 emitted only after the 4th valid nibble; invalid cycles do not advance the index.
